// File: rtl/sme_stimulus_driver.sv
// Host-side stimulus driver for the string-matching engine: buffers one string and one
// pattern, streams them over the chardata/isstring/ispattern handshake and captures the result.
module sme_stimulus_driver #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_str,
  input  logic       load_pat,
  input  logic [7:0] load_char,
  input  logic       clr_str,
  input  logic       clr_pat,
  input  logic       start,
  input  logic       send_str,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       busy,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       timeout
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SIW = $clog2(STR_MAX);
  localparam int PIW = $clog2(PAT_MAX);
  localparam int WW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_STR = 3'd1,
    ST_SEND_PAT = 3'd2,
    ST_WAIT     = 3'd3,
    ST_FIN      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [SLW-1:0]   str_len_q, str_len_d;
  logic [PLW-1:0]   pat_len_q, pat_len_d;
  logic [SLW-1:0]   idx_q, idx_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [7:0]       chardata_q, chardata_d;
  logic             isstring_q, isstring_d;
  logic             ispattern_q, ispattern_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             res_match_q, res_match_d;
  logic [4:0]       res_index_q, res_index_d;
  logic             timeout_q, timeout_d;
  logic             str_we_s, pat_we_s, start_ok_s;
  logic [SLW-1:0]   idx_inc_s;

  logic [7:0]       str_mem_q [STR_MAX];
  logic [7:0]       pat_mem_q [PAT_MAX];

  assign start_ok_s = start && (pat_len_q != PLW'(0));
  assign idx_inc_s  = idx_q + SLW'(1);

  // Next-state, buffer bookkeeping and result capture
  always_comb begin
    state_d     = state_q;
    str_len_d   = str_len_q;
    pat_len_d   = pat_len_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    timeout_d   = timeout_q;
    str_we_s    = 1'b0;
    pat_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          // an accepted start owns the cycle; same-cycle loads/clears are not applied
          timeout_d = 1'b0;
          idx_d     = SLW'(0);
          if (send_str && (str_len_q != SLW'(0))) begin
            state_d = ST_SEND_STR;
          end else begin
            state_d = ST_SEND_PAT;
          end
        end else begin
          if (clr_str) begin
            str_len_d = SLW'(0);
          end else if (load_str && (str_len_q != SLW'(STR_MAX))) begin
            str_we_s  = 1'b1;
            str_len_d = str_len_q + SLW'(1);
          end else begin
            str_len_d = str_len_q;
          end
          if (clr_pat) begin
            pat_len_d = PLW'(0);
          end else if (load_pat && (pat_len_q != PLW'(PAT_MAX))) begin
            pat_we_s  = 1'b1;
            pat_len_d = pat_len_q + PLW'(1);
          end else begin
            pat_len_d = pat_len_q;
          end
        end
      end
      ST_SEND_STR: begin
        if (idx_inc_s == str_len_q) begin
          state_d = ST_SEND_PAT;
          idx_d   = SLW'(0);
        end else begin
          idx_d = idx_inc_s;
        end
      end
      ST_SEND_PAT: begin
        if (idx_inc_s == SLW'(pat_len_q)) begin
          state_d = ST_WAIT;
          idx_d   = SLW'(0);
          wait_d  = WW'(0);
        end else begin
          idx_d = idx_inc_s;
        end
      end
      ST_WAIT: begin
        if (valid) begin
          res_match_d = match;
          res_index_d = match_index;
          state_d     = ST_FIN;
        end else if (wait_q == WW'(TIMEOUT)) begin
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          timeout_d   = 1'b1;
          state_d     = ST_FIN;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so outputs stay registered
  always_comb begin
    chardata_d  = 8'h00;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
    case (state_d)
      ST_SEND_STR: begin
        chardata_d = str_mem_q[idx_d[SIW-1:0]];
        isstring_d = 1'b1;
      end
      ST_SEND_PAT: begin
        chardata_d  = pat_mem_q[idx_d[PIW-1:0]];
        ispattern_d = 1'b1;
      end
      default: begin
        chardata_d = 8'h00;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      str_len_q   <= SLW'(0);
      pat_len_q   <= PLW'(0);
      idx_q       <= SLW'(0);
      wait_q      <= WW'(0);
      chardata_q  <= 8'h00;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= 5'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      timeout_q   <= timeout_d;
    end
  end

  // Character buffers; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (str_we_s) begin
      str_mem_q[str_len_q[SIW-1:0]] <= load_char;
    end
    if (pat_we_s) begin
      pat_mem_q[pat_len_q[PIW-1:0]] <= load_char;
    end
  end

  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/sme_stimulus_driver.md
# sme_stimulus_driver

Host-side driver for the string-matching engine's character-stream protocol. It holds one string (up to 32 chars) and one pattern (up to 8 chars) loaded by a host. On `start` it streams them to the engine using the `chardata`/`isstring`/`ispattern` handshake, then waits for the engine's `valid` and captures `match`/`match_index` as a result. It sits between a testbench or CPU register file and the matching engine, and is the transmitting end of that engine's input interface.

## Interface
Clocking and reset: one clock; reset is synchronous and active-high.

Parameters:
- `STR_MAX`, 32: string buffer depth; string length counter is 6 bits.
- `PAT_MAX`, 8: pattern buffer depth; pattern length counter is 4 bits.
- `TIMEOUT`, 255: maximum number of WAIT cycles before abort; wait counter is 8 bits.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_str` in 1: append `load_char` to the string buffer.
- `load_pat` in 1: append `load_char` to the pattern buffer.
- `load_char` in 8: character to append.
- `clr_str` in 1: set string length to 0.
- `clr_pat` in 1: set pattern length to 0.
- `start` in 1: begin a transaction.
- `send_str` in 1: sampled with `start`. 1 = send string then pattern; 0 = send pattern only, and the engine reuses its previous string.
- `chardata` out 8: character to engine.
- `isstring` out 1: `chardata` is a string character.
- `ispattern` out 1: `chardata` is a pattern character.
- `valid` in 1: engine result strobe.
- `match` in 1: engine match flag.
- `match_index` in 5: engine match position.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle result strobe.
- `res_match` out 1: captured match flag.
- `res_index` out 5: captured match position.
- `timeout` out 1: last transaction aborted without `valid`.

## Operation
States: IDLE, SEND_STR, SEND_PAT, WAIT, FIN.

- **IDLE**
  - `busy`=0.
  - `load_str`/`load_pat` write the buffer at the current length, then increment the length.
  - A write when length == MAX is dropped and the length saturates.
  - `clr_*` has priority over a same-cycle load of the same buffer.
  - `start` with pattern length 0 is ignored.
  - Otherwise `start` clears `done`/`timeout` and moves to:
    - SEND_STR if `send_str`=1 and string length > 0;
    - SEND_PAT in all other cases.
- **SEND_STR**
  - `isstring`=1, `ispattern`=0, `chardata`=str[i] for i = 0..strlen-1, one character per cycle.
  - After the last character, go to SEND_PAT. There is no gap between string and pattern.
- **SEND_PAT**
  - `ispattern`=1, `isstring`=0, `chardata`=pat[j] for j = 0..patlen-1.
  - After the last character, go to WAIT.
- **WAIT**
  - `isstring`=`ispattern`=0 and `chardata`=0.
  - The wait counter increments every cycle.
  - `valid`=1: capture `match` into `res_match` and `match_index` into `res_index`; go to FIN.
  - Counter reaches TIMEOUT without `valid`: `res_match`=0, `res_index`=0, `timeout`=1; go to FIN.
  - If `valid` and the timeout coincide, `valid` wins.
- **FIN**
  - `done`=1 for exactly one cycle, then IDLE.
  - `busy` is 1 in SEND_STR, SEND_PAT, WAIT and FIN.

Other rules:
- `start`, loads and clears are ignored while `busy`=1. Buffer contents persist across transactions.
- `valid` asserted during SEND_STR or SEND_PAT is ignored.
- Only one of `isstring`/`ispattern` is ever high in a cycle.
- `reset` returns to IDLE from any state mid-transaction. All outputs and both lengths go to 0; buffer contents are don't-care.

## Timing
- All outputs are registered.
- Reset values: `chardata`=0, `isstring`=0, `ispattern`=0, `busy`=0, `done`=0, `res_match`=0, `res_index`=0, `timeout`=0.
- `start` sampled in cycle t: first character is driven in cycle t+1.
- Stream occupies strlen+patlen consecutive cycles. With `send_str`=0, patlen cycles.
- WAIT entry: the first cycle with both strobes low follows the last pattern character.
- `valid` sampled in WAIT cycle w: `done`=1 in cycle w+1 with results already stable.
- Results hold until the next accepted `start`.
- Timeout: `done` follows TIMEOUT+1 cycles after WAIT entry.
- Minimum start-to-start spacing is strlen+patlen+3 cycles; `start` may be asserted in the cycle after `done`.

## Test plan
- **Load and send.** Load "hello world" (11 chars) and "^wor". Start with `send_str`=1; model returns `valid`, `match`=1, `match_index`=6 after 10 cycles.
  - Stream: 11 `isstring` cycles with correct chars, then 4 `ispattern` cycles.
  - Result: `done` pulse with `res_match`=1, `res_index`=6.
- **Pattern-only resend.** Clear and reload pattern "o$". Start with `send_str`=0.
  - Only 2 `ispattern` cycles, no `isstring`.
  - Model `match`=0 gives `res_match`=0.
- **Timeout.** Model never asserts `valid`.
  - `done` and `timeout`=1 exactly 256 cycles after WAIT entry; `res_index`=0.
- **Overflow and empty.** Load 35 string chars.
  - Length saturates at 32; `chardata` of cycle 32 = char #31.
  - `start` with empty pattern: `busy` stays 0.
- **Ignored inputs while busy.** `start`, `load_pat` and `clr_str` asserted mid-SEND_STR are ignored; `valid` pulsed during SEND_PAT is ignored.
  - Result comes only from the WAIT-phase `valid`; buffers unchanged afterwards.
- **Reset mid-transaction.** Assert `reset` in SEND_PAT.
  - Next cycle: all outputs 0, state IDLE.
  - Subsequent `start` is ignored until a pattern is reloaded, since the pattern length is now 0.
